// File: rtl/zion_riscv_isa_lib_add_sub_arb_if.sv
// Add/sub execution port: the decode side drives op and operands,
// the shared adder returns rslt combinationally.
interface ZionRiscvIsaLib_AddSubExItf #(
    parameter int CPU_WIDTH = 32,
    parameter int OP_W      = 2
);
    logic [OP_W-1:0]      op;
    logic [CPU_WIDTH-1:0] s1;
    logic [CPU_WIDTH-1:0] s2;
    logic [CPU_WIDTH-1:0] rslt;

    modport De (output op, s1, s2, input rslt);
    modport Ex (input op, s1, s2, output rslt);
endinterface

// File: rtl/zion_riscv_isa_lib_add_sub_arb.sv
// Round-robin front end sharing one add/sub unit between requesters,
// with a single-entry tagged response register.
module zion_riscv_isa_lib_add_sub_arb #(
    parameter bit  RV64    = 1'b0,
    parameter int  REQ_NUM = 3,
    localparam int CW      = RV64 ? 64 : 32,
    localparam int OW      = RV64 ? 3 : 2,
    localparam int IW      = $clog2(REQ_NUM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [REQ_NUM-1:0]          iReqVld,
    output logic [REQ_NUM-1:0]          oReqRdy,
    input  logic [REQ_NUM-1:0][OW-1:0]  iReqOp,
    input  logic [REQ_NUM-1:0][CW-1:0]  iReqS1,
    input  logic [REQ_NUM-1:0][CW-1:0]  iReqS2,
    input  logic [REQ_NUM-1:0]          iReqUnsigned,
    ZionRiscvIsaLib_AddSubExItf.De      oAddSubExIf,
    output logic                        oRspVld,
    input  logic                        iRspRdy,
    output logic [IW-1:0]               oRspId,
    output logic [CW-1:0]               oRspRslt,
    output logic                        oRspLt,
    output logic                        oRspErr
);

    logic          rsp_vld_q, rsp_vld_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [CW-1:0] rsp_rslt_q, rsp_rslt_d;
    logic          rsp_lt_q, rsp_lt_d;
    logic          rsp_err_q, rsp_err_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          win_vld;
    logic [IW-1:0] win;
    logic          can_acc;
    logic          acc;
    logic [OW-1:0] op_sel;
    logic [CW-1:0] s1_sel;
    logic [CW-1:0] s2_sel;
    logic          uns_sel;
    logic          err;
    logic          w_op;
    logic [CW-1:0] rslt_eff;
    logic          lt;
    int            h;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        int j;
        win_vld = 1'b0;
        win     = '0;
        j       = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            j = int'(ptr_q) + k;
            if (j >= REQ_NUM) j = j - REQ_NUM;
            if (!win_vld && iReqVld[j]) begin
                win_vld = 1'b1;
                win     = IW'(j);
            end
        end
    end

    assign can_acc = !rsp_vld_q || iRspRdy;
    assign acc     = rst_n && win_vld && can_acc;

    always_comb begin
        oReqRdy = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            oReqRdy[k] = acc && (win == IW'(k));
        end
    end

    assign op_sel  = iReqOp[win];
    assign s1_sel  = iReqS1[win];
    assign s2_sel  = iReqS2[win];
    assign uns_sel = iReqUnsigned[win];
    assign err     = (op_sel[0] & op_sel[1]) | ~(op_sel[0] | op_sel[1]);
    assign w_op    = RV64 && op_sel[OW-1];

    assign oAddSubExIf.op = (acc && !err) ? op_sel : '0;
    assign oAddSubExIf.s1 = acc ? s1_sel : '0;
    assign oAddSubExIf.s2 = acc ? s2_sel : '0;

    assign rslt_eff = err ? '0 : oAddSubExIf.rslt;

    // Operand signs differ under unsigned compare: s2's top bit decides.
    always_comb begin
        h  = w_op ? 31 : CW - 1;
        lt = (uns_sel && (s1_sel[h] ^ s2_sel[h])) ? s2_sel[h] : rslt_eff[h];
    end

    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_id_d   = rsp_id_q;
        rsp_rslt_d = rsp_rslt_q;
        rsp_lt_d   = rsp_lt_q;
        rsp_err_d  = rsp_err_q;
        ptr_d      = ptr_q;
        if (acc) begin
            rsp_vld_d  = 1'b1;
            rsp_id_d   = win;
            rsp_rslt_d = rslt_eff;
            rsp_lt_d   = lt;
            rsp_err_d  = err;
            ptr_d      = (win == IW'(REQ_NUM - 1)) ? '0 : win + IW'(1);
        end else if (rsp_vld_q && iRspRdy) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_rslt_q <= '0;
            rsp_lt_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            ptr_q      <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_rslt_q <= rsp_rslt_d;
            rsp_lt_q   <= rsp_lt_d;
            rsp_err_q  <= rsp_err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign oRspVld  = rsp_vld_q;
    assign oRspId   = rsp_id_q;
    assign oRspRslt = rsp_rslt_q;
    assign oRspLt   = rsp_lt_q;
    assign oRspErr  = rsp_err_q;

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_arb.sv
// Bench for the add/sub arbiter: reference model on a 32-bit x3 instance
// plus directed literal checks on both a 32-bit and a 64-bit x2 instance.
module tb_zion_riscv_isa_lib_add_sub_arb;

    logic clk;
    logic rst_n;

    logic [2:0]        vld;
    logic [2:0]        rrdy;
    logic [2:0][1:0]   op;
    logic [2:0][31:0]  s1;
    logic [2:0][31:0]  s2;
    logic [2:0]        uns;
    logic              rdy;
    logic              rvld;
    logic [1:0]        rid;
    logic [31:0]       rrslt;
    logic              rlt;
    logic              rerr;

    logic [1:0]        v_vld;
    logic [1:0]        v_rrdy;
    logic [1:0][2:0]   v_op;
    logic [1:0][63:0]  v_s1;
    logic [1:0][63:0]  v_s2;
    logic [1:0]        v_uns;
    logic              v_rdy;
    logic              v_rvld;
    logic [0:0]        v_rid;
    logic [63:0]       v_rrslt;
    logic              v_rlt;
    logic              v_rerr;

    int nchk = 0;
    int nerr = 0;
    int glog[$];

    ZionRiscvIsaLib_AddSubExItf #(.CPU_WIDTH(32), .OP_W(2)) if32 ();
    ZionRiscvIsaLib_AddSubExItf #(.CPU_WIDTH(64), .OP_W(3)) if64 ();

    // Stand-ins for the shared adder.
    assign if32.rslt = if32.op[1] ? if32.s1 - if32.s2 :
                       if32.op[0] ? if32.s1 + if32.s2 : 32'h0;

    logic [63:0] a64;
    always_comb begin
        a64 = if64.op[1] ? if64.s1 - if64.s2 :
              if64.op[0] ? if64.s1 + if64.s2 : 64'h0;
        if (if64.op[2]) a64 = {{32{a64[31]}}, a64[31:0]};
    end
    assign if64.rslt = a64;

    zion_riscv_isa_lib_add_sub_arb #(.RV64(1'b0), .REQ_NUM(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .iReqVld(vld), .oReqRdy(rrdy), .iReqOp(op),
        .iReqS1(s1), .iReqS2(s2), .iReqUnsigned(uns),
        .oAddSubExIf(if32),
        .oRspVld(rvld), .iRspRdy(rdy), .oRspId(rid),
        .oRspRslt(rrslt), .oRspLt(rlt), .oRspErr(rerr)
    );

    zion_riscv_isa_lib_add_sub_arb #(.RV64(1'b1), .REQ_NUM(2)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .iReqVld(v_vld), .oReqRdy(v_rrdy), .iReqOp(v_op),
        .iReqS1(v_s1), .iReqS2(v_s2), .iReqUnsigned(v_uns),
        .oAddSubExIf(if64),
        .oRspVld(v_rvld), .iRspRdy(v_rdy), .oRspId(v_rid),
        .oRspRslt(v_rrslt), .oRspLt(v_rlt), .oRspErr(v_rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic from the op rules.
    function automatic void calc(input logic [2:0] o, input logic [63:0] a,
                                 input logic [63:0] b, input logic u,
                                 input bit rv64, output logic [63:0] r,
                                 output logic l, output logic e);
        int w;
        int hb;
        w = rv64 ? 64 : 32;
        e = (o[0] && o[1]) || !(o[0] || o[1]) || (!rv64 && o[2]);
        r = o[1] ? a - b : a + b;
        if (!rv64) r = r & 64'hFFFF_FFFF;
        if (rv64 && o[2]) r = {{32{r[31]}}, r[31:0]};
        if (e) r = 64'h0;
        hb = (rv64 && o[2]) ? 31 : w - 1;
        l = (u && (a[hb] ^ b[hb])) ? b[hb] : r[hb];
    endfunction

    function automatic void pick(input logic [2:0] v, input int p,
                                 output bit f, output int g);
        f = 1'b0;
        g = 0;
        for (int k = 0; k < 3; k++) begin
            if (!f && v[(p + k) % 3]) begin
                f = 1'b1;
                g = (p + k) % 3;
            end
        end
    endfunction

    bit          m_vld = 1'b0;
    int          m_id = 0;
    logic [63:0] m_rslt = 64'h0;
    logic        m_lt = 1'b0;
    logic        m_err = 1'b0;
    int          m_ptr = 0;

    always @(posedge clk) begin
        bit          f;
        int          g;
        logic [63:0] r;
        logic        l;
        logic        e;
        if (!rst_n) begin
            m_vld = 1'b0; m_id = 0; m_rslt = 64'h0;
            m_lt = 1'b0; m_err = 1'b0; m_ptr = 0;
        end else begin
            pick(vld, m_ptr, f, g);
            if (f && (!m_vld || rdy)) begin
                calc({1'b0, op[g]}, {32'h0, s1[g]}, {32'h0, s2[g]}, uns[g],
                     1'b0, r, l, e);
                m_vld = 1'b1; m_id = g; m_rslt = r; m_lt = l; m_err = e;
                m_ptr = (g + 1) % 3;
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit          f;
        int          g;
        bit          a;
        logic [63:0] r;
        logic        l;
        logic        e;
        logic [2:0]  erdy;
        pick(vld, m_ptr, f, g);
        a = rst_n && f && (!m_vld || rdy);
        erdy = 3'b000;
        if (a) erdy[g] = 1'b1;
        chk("req_rdy", 64'(rrdy), 64'(erdy));
        chk("rsp_vld", 64'(rvld), 64'(m_vld));
        chk("rsp_id", 64'(rid), 64'(m_id));
        chk("rsp_rslt", 64'(rrslt), m_rslt);
        chk("rsp_lt", 64'(rlt), 64'(m_lt));
        chk("rsp_err", 64'(rerr), 64'(m_err));
        if (a) begin
            calc({1'b0, op[g]}, {32'h0, s1[g]}, {32'h0, s2[g]}, uns[g],
                 1'b0, r, l, e);
            chk("adder_op", 64'(if32.op), e ? 64'h0 : 64'(op[g]));
            chk("adder_s1", 64'(if32.s1), 64'(s1[g]));
        end else begin
            chk("adder_op_idle", 64'(if32.op), 64'h0);
            chk("adder_s1_idle", 64'(if32.s1), 64'h0);
        end
        for (int k = 0; k < 3; k++) begin
            if (rrdy[k]) glog.push_back(k);
        end
    end

    initial begin
        int exp_order[6];
        exp_order = '{0, 1, 2, 0, 1, 2};

        rst_n = 1'b0;
        vld = 3'b001; op = '0; s1 = '0; s2 = '0; uns = '0; rdy = 1'b1;
        v_vld = '0; v_op = '0; v_s1 = '0; v_s2 = '0; v_uns = '0; v_rdy = 1'b1;
        op[0] = 2'b01; s1[0] = 32'd5; s2[0] = 32'd7;
        step(); step(); step();
        chk("reset_rsp_vld", 64'(rvld), 64'h0);
        chk("reset_req_rdy", 64'(rrdy), 64'h0);

        rst_n = 1'b1;
        step();
        vld = 3'b000;
        chk("first_vld", 64'(rvld), 64'h1);
        chk("first_id", 64'(rid), 64'h0);
        chk("first_rslt", 64'(rrslt), 64'd12);

        rdy = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midreset_vld", 64'(rvld), 64'h0);
        rst_n = 1'b1;
        glog.delete();

        op[0] = 2'b01; s1[0] = 32'd100;        s2[0] = 32'd23;
        op[1] = 2'b10; s1[1] = 32'hFFFF_FFFF; s2[1] = 32'd1; uns[1] = 1'b1;
        op[2] = 2'b10; s1[2] = 32'hFFFF_FFFF; s2[2] = 32'd1; uns[2] = 1'b0;
        vld = 3'b111;
        rdy = 1'b1;
        repeat (6) step();
        chk("rr_count", 64'(glog.size()), 64'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), 64'(glog[i]), 64'(exp_order[i]));
        end

        rdy = 1'b0;
        repeat (5) step();
        chk("bp_rdy", 64'(rrdy), 64'h0);
        chk("bp_id", 64'(rid), 64'd2);
        chk("bp_rslt", 64'(rrslt), 64'hFFFF_FFFE);
        chk("bp_lt", 64'(rlt), 64'h1);
        rdy = 1'b1;
        #1;
        chk("bp_release_grant", 64'(rrdy), 64'b001);
        step();
        vld = 3'b000;

        vld = 3'b010;
        step();
        vld = 3'b000;
        chk("ltu_lt", 64'(rlt), 64'h0);
        chk("ltu_rslt", 64'(rrslt), 64'hFFFF_FFFE);
        chk("ltu_id", 64'(rid), 64'd1);
        uns[1] = 1'b0;
        vld = 3'b010;
        step();
        vld = 3'b000;
        chk("lts_lt", 64'(rlt), 64'h1);

        op[2] = 2'b11; s1[2] = 32'd5; s2[2] = 32'd3;
        vld = 3'b100;
        step();
        vld = 3'b000;
        chk("ill_err", 64'(rerr), 64'h1);
        chk("ill_rslt", 64'(rrslt), 64'h0);
        chk("ill_id", 64'(rid), 64'd2);
        vld = 3'b111;
        #1;
        chk("ill_ptr_adv", 64'(rrdy), 64'b001);
        op[0] = 2'b00;
        vld = 3'b001;
        step();
        vld = 3'b000;
        chk("ill0_err", 64'(rerr), 64'h1);
        chk("ill0_rslt", 64'(rrslt), 64'h0);
        step();
        step();
        chk("drain_vld", 64'(rvld), 64'h0);

        v_op[1] = 3'b110; v_s1[1] = 64'h0000_0000_8000_0000; v_s2[1] = 64'h0;
        v_vld = 2'b10;
        step();
        v_vld = 2'b00;
        chk("subw_vld", 64'(v_rvld), 64'h1);
        chk("subw_id", 64'(v_rid), 64'h1);
        chk("subw_rslt", v_rrslt, 64'hFFFF_FFFF_8000_0000);
        chk("subw_lt", 64'(v_rlt), 64'h1);
        chk("subw_err", 64'(v_rerr), 64'h0);

        v_op[0] = 3'b001; v_s1[0] = 64'h1_0000_0000; v_s2[0] = 64'd5;
        v_vld = 2'b01;
        step();
        v_vld = 2'b00;
        chk("add64_rslt", v_rrslt, 64'h1_0000_0005);
        chk("add64_id", 64'(v_rid), 64'h0);

        v_op[0] = 3'b010; v_s1[0] = 64'h0000_0000_8000_0000; v_s2[0] = 64'h0;
        v_vld = 2'b01;
        step();
        v_vld = 2'b00;
        chk("sub64_rslt", v_rrslt, 64'h0000_0000_8000_0000);
        chk("sub64_lt", 64'(v_rlt), 64'h0);

        v_op[0] = 3'b011;
        v_vld = 2'b01;
        step();
        v_vld = 2'b00;
        chk("ill64_err", 64'(v_rerr), 64'h1);
        chk("ill64_rslt", v_rrslt, 64'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
